block_bias_scan: RTL and testbench

//  Upstream stage of the exponent-bias normaliser in the fp_add datapath. Buffers one block of

---
 rtl/block_bias_scan_pkg.sv | 34 +++
 rtl/block_buf_ram.sv | 30 +++
 rtl/block_bias_scan.sv | 178 +++++++++++++++++
 tb/tb_block_bias_scan.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/block_bias_scan_pkg.sv
// Shared definitions for the block exponent-bias scan stage of the fp_add datapath:
// minifloat field geometry, FSM state type and the exponent-to-bias fitting helper.
package block_bias_scan_pkg;

  // Minifloat geometry; the element bus carries 2*SIZE bits.
  localparam int unsigned SIZE     = 8;
  localparam int unsigned NEXP     = 2;
  localparam int unsigned NSIG     = 5;
  localparam int unsigned EXP_BIAS = 2;
  localparam int unsigned FW       = 2 * SIZE;

  // Largest value representable in exp_overflow.
  localparam int unsigned BIAS_MAX = (1 << EXP_BIAS) - 1;

  // Block scan FSM states.
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    LATCH   = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  // Fit a raw exponent into the bias field: zero-extend when it fits,
  // otherwise saturate to the largest representable offset.
  function automatic logic [EXP_BIAS-1:0] fit_bias(input logic [NEXP-1:0] e);
    logic [EXP_BIAS-1:0] r;
    if (32'(e) > BIAS_MAX) begin
      r = '1;
    end else begin
      r = EXP_BIAS'(e);
    end
    return r;
  endfunction

endpackage

// File: rtl/block_buf_ram.sv
// Block buffer: DEPTH x WIDTH storage with one synchronous write port and
// one asynchronous read port, shaped to map onto distributed RAM.
module block_buf_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: contents are never reset, every slot is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read port.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/block_bias_scan.sv
// Upstream stage of the exponent-bias normaliser. Collects BLOCK_LEN adder
// results, tracks the smallest non-zero exponent, latches it as the shared
// exp_overflow and then replays the block unchanged.
module block_bias_scan
  import block_bias_scan_pkg::*;
#(
  parameter int unsigned BLOCK_LEN = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*SIZE-1:0]   in_f,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*SIZE-1:0]   out_f,
  output logic [EXP_BIAS-1:0] exp_overflow,
  output logic                out_first,
  output logic                out_last
);

  localparam int unsigned   CW       = $clog2(BLOCK_LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(BLOCK_LEN - 1);

  state_e              state_q,        state_d;
  logic [CW-1:0]       wr_cnt_q,       wr_cnt_d;
  logic [CW-1:0]       rd_cnt_q,       rd_cnt_d;
  logic [NEXP-1:0]     min_exp_q,      min_exp_d;
  logic                any_nz_q,       any_nz_d;
  logic [EXP_BIAS-1:0] exp_overflow_q, exp_overflow_d;
  logic                out_valid_q,    out_valid_d;
  logic [FW-1:0]       out_f_q,        out_f_d;
  logic                out_first_q,    out_first_d;
  logic                out_last_q,     out_last_d;
  logic                in_ready_q,     in_ready_d;

  logic                in_xfer;
  logic                out_xfer;
  logic [NEXP-1:0]     in_exp;
  logic [CW-1:0]       rd_addr;
  logic [FW-1:0]       rd_data;

  // Handshake qualifiers and exponent field extraction.
  always_comb begin
    in_xfer  = in_valid & in_ready_q;
    out_xfer = out_valid_q & out_ready;
    in_exp   = in_f[NEXP+NSIG-1:NSIG];
  end

  // out_f is registered, so the read address looks one element ahead:
  // element 0 while in LATCH, rd_cnt+1 while draining.
  always_comb begin
    rd_addr = (state_q == LATCH) ? '0 : rd_cnt_q + 1'b1;
  end

  block_buf_ram #(
    .DEPTH (BLOCK_LEN),
    .WIDTH (FW),
    .AW    (CW)
  ) u_buf (
    .clk   (clk),
    .we    (in_xfer),
    .waddr (wr_cnt_q),
    .wdata (in_f),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Next-state logic for the collect / latch / drain sequence.
  always_comb begin
    state_d        = state_q;
    wr_cnt_d       = wr_cnt_q;
    rd_cnt_d       = rd_cnt_q;
    min_exp_d      = min_exp_q;
    any_nz_d       = any_nz_q;
    exp_overflow_d = exp_overflow_q;
    out_valid_d    = out_valid_q;
    out_f_d        = out_f_q;
    out_first_d    = out_first_q;
    out_last_d     = out_last_q;
    in_ready_d     = in_ready_q;

    case (state_q)
      COLLECT: begin
        if (in_xfer) begin
          // Zero exponents (zero/subnormal) never lower the minimum.
          if (in_exp != '0) begin
            any_nz_d = 1'b1;
            if (in_exp < min_exp_q) begin
              min_exp_d = in_exp;
            end
          end
          // The write counter parks on the last index; only the drain end clears it.
          if (wr_cnt_q == LAST_IDX) begin
            state_d    = LATCH;
            in_ready_d = 1'b0;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end

      LATCH: begin
        exp_overflow_d = any_nz_q ? fit_bias(min_exp_q) : '0;
        rd_cnt_d       = '0;
        out_valid_d    = 1'b1;
        out_f_d        = rd_data;
        out_first_d    = 1'b1;
        out_last_d     = (LAST_IDX == '0);
        state_d        = DRAIN;
      end

      DRAIN: begin
        if (out_xfer) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_first_d = 1'b0;
            out_last_d  = 1'b0;
            wr_cnt_d    = '0;
            min_exp_d   = '1;
            any_nz_d    = 1'b0;
            in_ready_d  = 1'b1;
            state_d     = COLLECT;
          end else begin
            rd_cnt_d    = rd_cnt_q + 1'b1;
            out_f_d     = rd_data;
            out_first_d = 1'b0;
            out_last_d  = (rd_cnt_q + 1'b1 == LAST_IDX);
          end
        end
      end

      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // State and registered outputs; reset abandons any partial block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= COLLECT;
      wr_cnt_q       <= '0;
      rd_cnt_q       <= '0;
      min_exp_q      <= '1;
      any_nz_q       <= 1'b0;
      exp_overflow_q <= '0;
      out_valid_q    <= 1'b0;
      out_f_q        <= '0;
      out_first_q    <= 1'b0;
      out_last_q     <= 1'b0;
      in_ready_q     <= 1'b1;
    end else begin
      state_q        <= state_d;
      wr_cnt_q       <= wr_cnt_d;
      rd_cnt_q       <= rd_cnt_d;
      min_exp_q      <= min_exp_d;
      any_nz_q       <= any_nz_d;
      exp_overflow_q <= exp_overflow_d;
      out_valid_q    <= out_valid_d;
      out_f_q        <= out_f_d;
      out_first_q    <= out_first_d;
      out_last_q     <= out_last_d;
      in_ready_q     <= in_ready_d;
    end
  end

  // Drive ports from the registered state.
  always_comb begin
    in_ready     = in_ready_q;
    out_valid    = out_valid_q;
    out_f        = out_f_q;
    out_first    = out_first_q;
    out_last     = out_last_q;
    exp_overflow = exp_overflow_q;
  end

endmodule

// File: tb/tb_block_bias_scan.sv
// Directed bench for block_bias_scan: reset values, min-exponent latching,
// zero-exponent handling, backpressure, back-to-back blocks and mid-block reset.
module tb_block_bias_scan;
  import block_bias_scan_pkg::*;

  localparam int BL = 16;

  typedef logic [2*SIZE-1:0]   blk_t  [BL];
  typedef logic [NEXP-1:0]     exps_t [BL];

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [2*SIZE-1:0]   in_f = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [2*SIZE-1:0]   out_f;
  logic [EXP_BIAS-1:0] exp_overflow;
  logic                out_first;
  logic                out_last;

  int n_checks = 0;
  int n_errors = 0;

  block_bias_scan #(.BLOCK_LEN(BL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_f         (in_f),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_f        (out_f),
    .exp_overflow (exp_overflow),
    .out_first    (out_first),
    .out_last     (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Build a block with distinct sign/sig/upper bits around the given exponents.
  function automatic blk_t make_blk(input exps_t e, input int seed);
    blk_t b;
    for (int i = 0; i < BL; i++) begin
      b[i] = {8'(seed * 16 + i), 1'(i % 2), e[i], 5'(seed + 3 * i)};
    end
    return b;
  endfunction

  // Push n elements; exp_overflow must hold hold_ov throughout collection.
  task automatic send(input blk_t b, input int n, input logic [EXP_BIAS-1:0] hold_ov,
                      output int first_wait);
    int   budget;
    logic acc;
    first_wait = 0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_f     = b[i];
      acc      = 1'b0;
      budget   = 0;
      while (!acc && budget < 50) begin
        acc = in_ready;
        check("hold_ov", 32'(exp_overflow), 32'(hold_ov));
        tick();
        budget++;
        if (!acc && i == 0) first_wait++;
      end
      if (!acc) check("in_accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  // Take n elements from the drain, optionally with out_ready pattern 1,0,0,1.
  task automatic recv(input blk_t b, input int n, input logic [EXP_BIAS-1:0] ov,
                      input logic stall);
    int               idx;
    int               cyc;
    logic             prev_stall;
    logic [2*SIZE-1:0] prev_f;
    idx        = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    prev_f     = '0;
    while (idx < n && cyc < 200) begin
      out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (out_valid) begin
        check("out_f", 32'(out_f), 32'(b[idx]));
        check("out_first", 32'(out_first), 32'(idx == 0));
        check("out_last", 32'(out_last), 32'(idx == BL - 1));
        check("drain_ov", 32'(exp_overflow), 32'(ov));
        check("drain_in_ready", 32'(in_ready), 0);
        if (prev_stall) check("stall_hold", 32'(out_f), 32'(prev_f));
        prev_stall = !out_ready;
        prev_f     = out_f;
        if (out_ready) idx++;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    if (idx < n) check("drain_timeout", 32'(idx), 32'(n));
  endtask

  // After the last input: LATCH cycle without valid, then DRAIN with new bias.
  task automatic check_latency(input logic [EXP_BIAS-1:0] ov);
    check("latch_no_valid", 32'(out_valid), 0);
    check("latch_in_ready", 32'(in_ready), 0);
    tick();
    check("first_valid", 32'(out_valid), 1);
    check("first_ov", 32'(exp_overflow), 32'(ov));
  endtask

  task automatic check_block_done();
    check("done_valid", 32'(out_valid), 0);
    check("done_in_ready", 32'(in_ready), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_ov", 32'(exp_overflow), 0);
    check("rst_out_f", 32'(out_f), 0);
    check("rst_first_last", 32'({out_first, out_last}), 0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid_post", 32'(out_valid), 0);
  endtask

  initial begin
    exps_t e;
    blk_t  b, b2;
    int    fw;

    // 1: reset values
    do_reset();

    // 2: all non-zero exponents, min 1, free-flowing drain
    e = '{2'd3, 2'd2, 2'd1, 2'd3, 2'd2, 2'd3, 2'd3, 2'd2,
          2'd1, 2'd3, 2'd2, 2'd3, 2'd3, 2'd3, 2'd2, 2'd1};
    b = make_blk(e, 1);
    send(b, BL, 2'd0, fw);
    check_latency(2'd1);
    recv(b, BL, 2'd1, 1'b0);
    check_block_done();

    // 3a: every exponent zero gives no offset
    e = '{default: 2'd0};
    b = make_blk(e, 2);
    send(b, BL, 2'd1, fw);
    check_latency(2'd0);
    recv(b, BL, 2'd0, 1'b0);
    check_block_done();

    // 3b: zeros mixed with 2 are ignored
    for (int i = 0; i < BL; i++) e[i] = (i % 2 == 0) ? 2'd0 : 2'd2;
    b = make_blk(e, 3);
    send(b, BL, 2'd0, fw);
    check_latency(2'd2);
    recv(b, BL, 2'd2, 1'b0);
    check_block_done();

    // 4: backpressure 1,0,0,1 during drain, all exps 3
    e = '{default: 2'd3};
    b = make_blk(e, 4);
    send(b, BL, 2'd2, fw);
    check_latency(2'd3);
    recv(b, BL, 2'd3, 1'b1);
    check_block_done();

    // 5: back-to-back A (min 2) then B (min 1)
    for (int i = 0; i < BL; i++) e[i] = (i % 2 == 0) ? 2'd2 : 2'd3;
    b = make_blk(e, 5);
    send(b, BL, 2'd3, fw);
    check_latency(2'd2);
    recv(b, BL, 2'd2, 1'b0);
    e = '{default: 2'd3};
    e[0] = 2'd0;
    e[9] = 2'd1;
    b2 = make_blk(e, 6);
    send(b2, BL, 2'd2, fw);
    check("b_first_wait", 32'(fw), 0);
    check("ov_hold_latch", 32'(exp_overflow), 2);
    check_latency(2'd1);
    recv(b2, BL, 2'd1, 1'b0);
    check_block_done();

    // 6a: reset after 7 inputs of a min-1 block, then a min-2 block
    e = '{default: 2'd1};
    b = make_blk(e, 7);
    send(b, 7, 2'd1, fw);
    do_reset();
    e = '{default: 2'd3};
    e[5] = 2'd2;
    b = make_blk(e, 8);
    send(b, BL, 2'd0, fw);
    check_latency(2'd2);
    recv(b, BL, 2'd2, 1'b0);
    check_block_done();

    // 6b: reset mid-drain of a min-1 block, then a min-3 block
    e = '{default: 2'd1};
    b = make_blk(e, 9);
    send(b, BL, 2'd2, fw);
    check_latency(2'd1);
    recv(b, 5, 2'd1, 1'b0);
    do_reset();
    e = '{default: 2'd3};
    b = make_blk(e, 10);
    send(b, BL, 2'd0, fw);
    check_latency(2'd3);
    recv(b, BL, 2'd3, 1'b0);
    check_block_done();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
